i2c_bus_monitor: RTL

//  Passive, parametrised multi-bus I2C protocol monitor, synthesizable RTL.
//  Per bus: synchronises and deglitches SCL/SDA, decodes START/RSTART/STOP,

---
 rtl/i2c_bus_monitor.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_bus_monitor.sv
// Passive multi-bus I2C monitor: syncs and deglitches SCL/SDA, decodes bus conditions,
// assembles bytes with ACK/NACK, flags SCL-low timeouts and SDA contention. Never drives.
module i2c_bus_monitor #(
    parameter int unsigned NUM_BUS     = 1,
    parameter int unsigned FILT_CYC    = 3,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                   system_clock,
    input  logic                   reset,
    input  logic [NUM_BUS-1:0]     scl_i,
    input  logic [NUM_BUS-1:0]     sda_i,
    input  logic [NUM_BUS-1:0]     sda_rel_i,
    input  logic [NUM_BUS-1:0]     clr_i,
    output logic [NUM_BUS-1:0]     evt_valid_o,
    output logic [3*NUM_BUS-1:0]   evt_code_o,
    output logic [8*NUM_BUS-1:0]   evt_data_o,
    output logic [NUM_BUS-1:0]     busy_o,
    output logic [NUM_BUS-1:0]     timeout_o,
    output logic [NUM_BUS-1:0]     contention_o
);
    localparam int unsigned FW = $clog2(FILT_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] EvStart   = 3'd1;
    localparam logic [2:0] EvRstart  = 3'd2;
    localparam logic [2:0] EvStop    = 3'd3;
    localparam logic [2:0] EvAck     = 3'd4;
    localparam logic [2:0] EvNack    = 3'd5;
    localparam logic [2:0] EvTimeout = 3'd6;
    localparam logic [2:0] EvContend = 3'd7;

    typedef enum logic {StIdle, StActive} state_e;

    for (genvar b = 0; b < NUM_BUS; b++) begin : g_bus
        logic [1:0]    scl_sync_q, sda_sync_q, rel_sync_q;
        logic          scl_f_q, sda_f_q, scl_p_q, sda_p_q;
        logic [FW-1:0] scl_fc_q, sda_fc_q;
        state_e        state_q, state_d;
        logic [3:0]    bit_cnt_q, bit_cnt_d;
        logic [7:0]    shift_q, shift_d;
        logic          ack_q, ack_d;
        logic [TW-1:0] to_cnt_q, to_cnt_d;
        logic          valid_q, valid_d;
        logic [2:0]    code_q, code_d;
        logic [7:0]    data_q, data_d;
        logic          tout_q, tout_d, cont_q, cont_d;
        logic          start_c, stop_c, rise_c, fall_c;

        always_ff @(posedge system_clock) begin
            if (reset) begin
                scl_sync_q <= 2'b11;
                sda_sync_q <= 2'b11;
                rel_sync_q <= 2'b00;
                scl_f_q    <= 1'b1;
                sda_f_q    <= 1'b1;
                scl_p_q    <= 1'b1;
                sda_p_q    <= 1'b1;
                scl_fc_q   <= '0;
                sda_fc_q   <= '0;
                state_q    <= StIdle;
                bit_cnt_q  <= '0;
                shift_q    <= '0;
                ack_q      <= 1'b0;
                to_cnt_q   <= '0;
                valid_q    <= 1'b0;
                code_q     <= '0;
                data_q     <= '0;
                tout_q     <= 1'b0;
                cont_q     <= 1'b0;
            end else begin
                scl_sync_q <= {scl_sync_q[0], scl_i[b]};
                sda_sync_q <= {sda_sync_q[0], sda_i[b]};
                rel_sync_q <= {rel_sync_q[0], sda_rel_i[b]};
                // A level is accepted on the FILT_CYC-th consecutive differing cycle.
                if (scl_sync_q[1] != scl_f_q) begin
                    if (scl_fc_q == FW'(FILT_CYC - 1)) begin
                        scl_f_q  <= scl_sync_q[1];
                        scl_fc_q <= '0;
                    end else begin
                        scl_fc_q <= scl_fc_q + 1'b1;
                    end
                end else begin
                    scl_fc_q <= '0;
                end
                if (sda_sync_q[1] != sda_f_q) begin
                    if (sda_fc_q == FW'(FILT_CYC - 1)) begin
                        sda_f_q  <= sda_sync_q[1];
                        sda_fc_q <= '0;
                    end else begin
                        sda_fc_q <= sda_fc_q + 1'b1;
                    end
                end else begin
                    sda_fc_q <= '0;
                end
                scl_p_q   <= scl_f_q;
                sda_p_q   <= sda_f_q;
                state_q   <= state_d;
                bit_cnt_q <= bit_cnt_d;
                shift_q   <= shift_d;
                ack_q     <= ack_d;
                to_cnt_q  <= to_cnt_d;
                valid_q   <= valid_d;
                code_q    <= code_d;
                data_q    <= data_d;
                tout_q    <= tout_d;
                cont_q    <= cont_d;
            end
        end

        assign start_c = scl_p_q & scl_f_q & sda_p_q & ~sda_f_q;
        assign stop_c  = scl_p_q & scl_f_q & ~sda_p_q & sda_f_q;
        assign rise_c  = ~scl_p_q & scl_f_q;
        assign fall_c  = scl_p_q & ~scl_f_q;

        always_comb begin
            state_d   = state_q;
            bit_cnt_d = bit_cnt_q;
            shift_d   = shift_q;
            ack_d     = ack_q;
            valid_d   = 1'b0;
            code_d    = code_q;
            data_d    = data_q;
            tout_d    = tout_q & ~clr_i[b];
            cont_d    = cont_q & ~clr_i[b];
            to_cnt_d  = '0;
            if (state_q == StActive && !scl_f_q) begin
                to_cnt_d = (to_cnt_q == TW'(TIMEOUT_CYC)) ? to_cnt_q : to_cnt_q + 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start_c) begin
                        state_d   = StActive;
                        bit_cnt_d = '0;
                        valid_d   = 1'b1;
                        code_d    = EvStart;
                    end
                end
                StActive: begin
                    if (start_c) begin
                        bit_cnt_d = '0;
                        valid_d   = 1'b1;
                        code_d    = EvRstart;
                    end else if (stop_c) begin
                        state_d   = StIdle;
                        bit_cnt_d = '0;
                        valid_d   = 1'b1;
                        code_d    = EvStop;
                    end else if (!scl_f_q && to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                        state_d   = StIdle;
                        bit_cnt_d = '0;
                        to_cnt_d  = '0;
                        valid_d   = 1'b1;
                        code_d    = EvTimeout;
                        tout_d    = 1'b1;
                    end else begin
                        if (rise_c) begin
                            if (bit_cnt_q < 4'd8) begin
                                shift_d = {shift_q[6:0], sda_f_q};
                            end else if (bit_cnt_q == 4'd8) begin
                                ack_d = sda_f_q;
                            end
                            if (bit_cnt_q <= 4'd8) begin
                                bit_cnt_d = bit_cnt_q + 4'd1;
                            end
                            if (rel_sync_q[1] && !sda_f_q) begin
                                valid_d = 1'b1;
                                code_d  = EvContend;
                                cont_d  = 1'b1;
                            end
                        end
                        if (fall_c && bit_cnt_q == 4'd9) begin
                            bit_cnt_d = '0;
                            if (!valid_d) begin
                                valid_d = 1'b1;
                                code_d  = ack_q ? EvNack : EvAck;
                                data_d  = shift_q;
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        assign evt_valid_o[b]       = valid_q;
        assign evt_code_o[3*b +: 3] = code_q;
        assign evt_data_o[8*b +: 8] = data_q;
        assign busy_o[b]            = (state_q == StActive);
        assign timeout_o[b]         = tout_q;
        assign contention_o[b]      = cont_q;
    end
endmodule
